// File: rtl/bm_buf_free_list_pkg.sv
// -----------------------------------------------------------------------------
// bm_buf_free_list_pkg
//   Shared definitions for the buffer-manager free-pointer pool:
//   default widths, the low-watermark default and the controller state
//   encoding. Imported by bm_buf_free_list.
// -----------------------------------------------------------------------------
package bm_buf_free_list_pkg;

  // Default buffer pointer width; the pool holds 2^DFLT_BUF_PTR_NBITS buffers.
  localparam int DFLT_BUF_PTR_NBITS = 10;
  // Default width of the releasing port id.
  localparam int DFLT_PORT_ID_NBITS = 3;
  // Default low watermark: free_low asserts when the free count is below it.
  localparam int DFLT_LOW_WM        = 16;

  // Controller state. INIT fills the FIFO with every pointer once after
  // reset; READY is terminal until the next reset.
  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } fl_state_t;

endpackage : bm_buf_free_list_pkg

// File: rtl/bm_buf_free_list_ram_1r1w.sv
// -----------------------------------------------------------------------------
// ram_1r1w
//   Simple dual-port storage: one synchronous write port and one read port
//   with a registered output. Used as the circular FIFO array of the free
//   pointer pool. Array contents are not reset.
//
// Ports
//   clk      in   clock
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_en    in   read strobe; rd_data updates one cycle later
//   rd_addr  in   read address
//   rd_data  out  registered read data (holds when rd_en=0)
// -----------------------------------------------------------------------------
module ram_1r1w #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read and write never target the same entry in one cycle: the pool
  // only reads when count != 0 and only writes when count != full, so
  // rd_ptr == wr_ptr with both active cannot occur.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule : ram_1r1w

// File: rtl/bm_buf_free_list.sv
// -----------------------------------------------------------------------------
// bm_buf_free_list
//   Free buffer-pointer pool for the shared packet memory. Every free
//   pointer lives in a circular FIFO. After reset the pool sweeps the FIFO,
//   writing pointer i into entry i, then becomes READY. In READY it grants
//   one pointer per cycle to the aggregator and reclaims one released
//   pointer per cycle from the shared memory.
//
// Ports
//   clk                 in   clock
//   rst_n               in   asynchronous active-low reset
//   alloc_req           in   request one pointer (legal only while free_avail)
//   alloc_gnt           out  alloc_buf_ptr valid this cycle
//   alloc_buf_ptr       out  granted pointer (0 when alloc_gnt=0)
//   tm_rel_buf_valid    in   release strobe
//   tm_rel_buf_port_id  in   releasing port, captured on overflow only
//   tm_rel_buf_ptr      in   released pointer
//   free_avail          out  READY and free count != 0
//   free_low            out  free count < LOW_WM
//   free_count          out  current free count
//   init_done           out  initialisation sweep complete
//   err_underflow       out  pulse: alloc_req while nothing available
//   err_overflow        out  pulse: release dropped (pool full or INIT)
//   err_port_id         out  port id of the last dropped release
// -----------------------------------------------------------------------------
module bm_buf_free_list
  import bm_buf_free_list_pkg::*;
#(
  parameter int BUF_PTR_NBITS = DFLT_BUF_PTR_NBITS,
  parameter int PORT_ID_NBITS = DFLT_PORT_ID_NBITS,
  parameter int LOW_WM        = DFLT_LOW_WM
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alloc_req,
  output logic                     alloc_gnt,
  output logic [BUF_PTR_NBITS-1:0] alloc_buf_ptr,
  input  logic                     tm_rel_buf_valid,
  input  logic [PORT_ID_NBITS-1:0] tm_rel_buf_port_id,
  input  logic [BUF_PTR_NBITS-1:0] tm_rel_buf_ptr,
  output logic                     free_avail,
  output logic                     free_low,
  output logic [BUF_PTR_NBITS:0]   free_count,
  output logic                     init_done,
  output logic                     err_underflow,
  output logic                     err_overflow,
  output logic [PORT_ID_NBITS-1:0] err_port_id
);

  localparam int                     DEPTH      = 1 << BUF_PTR_NBITS;
  localparam logic [BUF_PTR_NBITS:0] FULL_COUNT = (BUF_PTR_NBITS+1)'(DEPTH);
  localparam logic [BUF_PTR_NBITS:0] LOW_WM_C   = (BUF_PTR_NBITS+1)'(LOW_WM);
  localparam logic [BUF_PTR_NBITS-1:0] LAST_IDX = '1;

  fl_state_t                  state;
  fl_state_t                  state_nxt;
  logic [BUF_PTR_NBITS-1:0]   rd_ptr;
  logic [BUF_PTR_NBITS-1:0]   wr_ptr;
  logic [BUF_PTR_NBITS:0]     count;
  logic [BUF_PTR_NBITS:0]     count_nxt;

  logic                       init_wr;
  logic                       alloc_ok;
  logic                       rel_ok;
  logic                       underflow_nxt;
  logic                       overflow_nxt;

  logic                       ram_wr_en;
  logic [BUF_PTR_NBITS-1:0]   ram_wr_data;
  logic [BUF_PTR_NBITS-1:0]   ram_rd_data;

  // ---------------------------------------------------------------------------
  // Next-state and per-cycle decisions. During INIT the write pointer doubles
  // as the sweep index, so it wraps to 0 exactly when the sweep finishes.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt     = state;
    init_wr       = 1'b0;
    alloc_ok      = 1'b0;
    rel_ok        = 1'b0;
    underflow_nxt = 1'b0;
    overflow_nxt  = 1'b0;

    case (state)
      ST_INIT: begin
        init_wr      = 1'b1;
        // Requests are silently ignored; releases have nowhere to go.
        overflow_nxt = tm_rel_buf_valid;
        if (wr_ptr == LAST_IDX) begin
          state_nxt = ST_READY;
        end
      end
      ST_READY: begin
        // Decisions use the count at the start of the cycle: a release at
        // count 0 is not bypassed to a same-cycle alloc, and a release at
        // full is dropped even if an alloc frees an entry this cycle.
        alloc_ok      = alloc_req && (count != '0);
        underflow_nxt = alloc_req && (count == '0);
        rel_ok        = tm_rel_buf_valid && (count != FULL_COUNT);
        overflow_nxt  = tm_rel_buf_valid && (count == FULL_COUNT);
      end
      default: begin
        state_nxt = ST_INIT;
      end
    endcase

    count_nxt = count
              + {{BUF_PTR_NBITS{1'b0}}, (init_wr | rel_ok)}
              - {{BUF_PTR_NBITS{1'b0}}, alloc_ok};
  end

  // ---------------------------------------------------------------------------
  // Storage: write port shared by the INIT sweep and releases, read port
  // driven by rd_ptr. The registered read output lines up with alloc_gnt.
  // ---------------------------------------------------------------------------
  assign ram_wr_en   = init_wr | rel_ok;
  assign ram_wr_data = init_wr ? wr_ptr : tm_rel_buf_ptr;

  ram_1r1w #(
    .WIDTH (BUF_PTR_NBITS),
    .DEPTH (DEPTH),
    .AW    (BUF_PTR_NBITS)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_wr_en),
    .wr_addr (wr_ptr),
    .wr_data (ram_wr_data),
    .rd_en   (alloc_ok),
    .rd_addr (rd_ptr),
    .rd_data (ram_rd_data)
  );

  // ---------------------------------------------------------------------------
  // Control registers. Status outputs are registered from the post-update
  // count so they describe the pool as it stands after this cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_INIT;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      alloc_gnt     <= 1'b0;
      free_avail    <= 1'b0;
      free_low      <= 1'b1;
      init_done     <= 1'b0;
      err_underflow <= 1'b0;
      err_overflow  <= 1'b0;
      err_port_id   <= '0;
    end else begin
      state         <= state_nxt;
      count         <= count_nxt;
      if (ram_wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (alloc_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      alloc_gnt     <= alloc_ok;
      free_avail    <= (state_nxt == ST_READY) && (count_nxt != '0);
      free_low      <= (count_nxt < LOW_WM_C);
      init_done     <= (state_nxt == ST_READY);
      err_underflow <= underflow_nxt;
      err_overflow  <= overflow_nxt;
      if (overflow_nxt) begin
        err_port_id <= tm_rel_buf_port_id;
      end
    end
  end

  assign free_count = count;

  // Gate the RAM data so the pointer bus is quiet (and 0 in reset) between
  // grants; the RAM output register itself carries no reset.
  assign alloc_buf_ptr = alloc_gnt ? ram_rd_data : '0;

endmodule : bm_buf_free_list

// File: doc/bm_buf_free_list.md
Name: bm_buf_free_list

Overview:
- Buffer-pointer free pool for the buffer manager shared packet memory.
- Sits directly downstream of the shared memory's buffer-release output (tm_rel_buf_*) and upstream of the aggregator, which takes pointers from it to use as write addresses into packet memory.
- Holds every free buffer pointer in a circular FIFO, self-initialises after reset, grants one pointer per cycle and reclaims one per cycle.

Parameters:
- BUF_PTR_NBITS, 10, buffer pointer width; pool holds 2^BUF_PTR_NBITS buffers.
- PORT_ID_NBITS, 3, width of the port id carried on release.
- LOW_WM, 16, free_low asserts when free count < LOW_WM.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- alloc_req  in  1  aggregator requests one buffer pointer.
- alloc_gnt  out  1  pointer on alloc_buf_ptr valid this cycle.
- alloc_buf_ptr  out  BUF_PTR_NBITS  granted pointer.
- tm_rel_buf_valid  in  1  buffer release strobe from shared memory.
- tm_rel_buf_port_id  in  PORT_ID_NBITS  port that released; used only for error capture.
- tm_rel_buf_ptr  in  BUF_PTR_NBITS  released pointer.
- free_avail  out  1  ready and count != 0; alloc_req is legal only while high.
- free_low  out  1  count < LOW_WM.
- free_count  out  BUF_PTR_NBITS+1  current free-pointer count.
- init_done  out  1  initialisation sweep complete.
- err_underflow  out  1  pulse: alloc_req seen while free_avail=0.
- err_overflow  out  1  pulse: release seen while pool full or during INIT.
- err_port_id  out  PORT_ID_NBITS  port id of the last overflow release.

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0:
  - all outputs are 0, except free_low=1 (count=0 < LOW_WM);
  - rd_ptr=wr_ptr=0, count=0, state=INIT.
- State INIT:
  - Each cycle writes init_idx into FIFO entry init_idx, then increments init_idx and count.
  - After writing entry 2^N-1: state -> READY, init_done=1 on the next cycle, count=2^N, wr_ptr wraps to 0.
  - alloc_req is ignored (no grant, no error).
  - A release in INIT is dropped and pulses err_overflow.
- State READY:
  - alloc_req with free_avail=1: FIFO read at rd_ptr; alloc_gnt=1 with alloc_buf_ptr exactly one cycle later (registered RAM output); rd_ptr+1 mod 2^N; count-1.
  - A release writes tm_rel_buf_ptr at wr_ptr; wr_ptr+1 mod 2^N; count+1.
  - Simultaneous alloc and release: both are serviced and count is unchanged.
  - At count=0, a same-cycle release is not bypassed to the alloc. The alloc is refused and err_underflow pulses; the release is stored.
  - A release at count=2^N is dropped; err_overflow pulses for 1 cycle and err_port_id is captured.
  - READY is terminal until reset. Reset mid-operation re-runs the full INIT sweep and all state is lost.
- Output timing:
  - free_avail, free_low and free_count are registered and reflect count after the current cycle's updates.
  - alloc_gnt is held 0 whenever no grant is due; alloc_buf_ptr is don't-care when alloc_gnt=0.
- Widths:
  - count is BUF_PTR_NBITS+1 bits and never wraps (guarded by the overflow and underflow checks).
  - rd_ptr and wr_ptr are BUF_PTR_NBITS bits and wrap naturally.
- Throughput: one alloc plus one release per cycle sustained, with no bubbles.
- No duplicate-pointer detection; a double release is the upstream block's bug.

Decomposition:
- Put BUF_PTR_NBITS, PORT_ID_NBITS and the state encodings (INIT=0, READY=1) in defines.vh, reusing the existing `BUF_PTR_NBITS/`PORT_ID_NBITS macros.
- Use one sub-module for storage: the existing ram_1r1w, width BUF_PTR_NBITS, depth 2^BUF_PTR_NBITS.
  - Write port is muxed between the INIT sweep and releases.
  - Read port is driven by rd_ptr.

Test Plan:
- Bench uses BUF_PTR_NBITS=4, LOW_WM=4.
- Reset release -> init_done rises after 16 cycles; free_count=16, free_avail=1, free_low=0.
- 16 back-to-back alloc_req -> grants with ptrs 0..15 in order, each 1 cycle after its req; then free_count=0, free_avail=0, free_low=1.
- At count=0, release ptr 7 plus simultaneous alloc_req -> err_underflow pulse, no grant; next cycle free_count=1; a later alloc grants 7.
- Steady state at count=8, alloc and release (ptr 3) every cycle for 20 cycles -> free_count stays 8; ptr 3 re-granted in FIFO order.
- At count=16, release ptr 5 from port 2 -> err_overflow 1-cycle pulse, err_port_id=2, count stays 16.
- rst_n asserted mid-traffic, deasserted two cycles later -> outputs cleared asynchronously; INIT repeats and grants restart at ptr 0.
